// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the raster timing outputs of vga_timing_gen so they travel as
//   one port into the pixel/colour stage and the sync output pins.
//
//   Signals:
//     pix_en      one-clk strobe marking each pixel step
//     hsync       horizontal sync, at the generator's SYNC_POL when active
//     vsync       vertical sync, at the generator's SYNC_POL when active
//     display_on  high while (hpos, vpos) is inside the visible area
//     hpos        current column, 0..H_TOTAL-1
//     vpos        current line, 0..V_TOTAL-1
//     line_start  one-clk pulse when hpos becomes 0
//     frame_start one-clk pulse when (hpos, vpos) becomes (0, 0)
//
//   Modports:
//     master  the timing generator that drives every signal
//     slave   any consumer of the raster timing
interface vga_timing_gen_if #(
  parameter int POS_W = 10
);

  logic             pix_en;
  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;
  logic             line_start;
  logic             frame_start;

  modport master (
    output pix_en,
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos,
    output line_start,
    output frame_start
  );

  modport slave (
    input pix_en,
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos,
    input line_start,
    input frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator. Divides clk down to a pixel cadence
//   (pix_en), walks a column/line counter pair across the full raster
//   (visible area plus porches and sync), and produces registered hsync,
//   vsync, display_on and line/frame start pulses aligned with hpos/vpos.
//   Defaults describe 640x480 inside an 800x525 total raster.
//
//   Ports:
//     clk    system clock
//     reset  synchronous, active-low reset
//     vga    vga_timing_gen_if.master carrying pix_en, hsync, vsync,
//            display_on, hpos, vpos, line_start, frame_start
//
//   Every output is a flop; no input reaches an output combinationally.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int POS_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Geometry and divider sanity checks at elaboration time.
  if (H_TOTAL >= (1 << POS_W) || V_TOTAL >= (1 << POS_W)) begin : g_bad_geometry
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in POS_W bits");
  end

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end

  // A 4-bit divider covers the whole 1..16 range.
  localparam logic [3:0]       DIV_LAST = 4'(CLK_DIV - 1);

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] HS_FIRST = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] HS_LAST  = POS_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [POS_W-1:0] VS_FIRST = POS_W'(V_DISPLAY + V_FRONT);
  localparam logic [POS_W-1:0] VS_LAST  = POS_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = !SYNC_ON;

  logic [3:0]       div_cnt;
  logic [3:0]       div_next;
  logic             step;
  logic [POS_W-1:0] hpos_q;
  logic [POS_W-1:0] vpos_q;
  logic [POS_W-1:0] h_next;
  logic [POS_W-1:0] v_next;
  logic             h_sync_zone;
  logic             v_sync_zone;
  logic             visible;
  logic             pix_en_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             display_q;
  logic             line_q;
  logic             frame_q;

  // The pixel step fires on the edge that leaves div_cnt == CLK_DIV-1, so
  // pix_en rises on that same edge and the counters move with it. With
  // CLK_DIV = 1 div_cnt sits at 0 and every edge is a step.
  always_comb begin
    step     = (div_cnt == DIV_LAST);
    div_next = step ? 4'd0 : div_cnt + 4'd1;
  end

  // Next raster position. Outside a step the position simply holds, which
  // lets the sync/display decode below run unconditionally.
  always_comb begin
    h_next = hpos_q;
    v_next = vpos_q;
    if (step) begin
      if (hpos_q == H_LAST) begin
        h_next = '0;
        v_next = (vpos_q == V_LAST) ? '0 : vpos_q + 1'b1;
      end else begin
        h_next = hpos_q + 1'b1;
      end
    end
  end

  // Decode from the next-state position so the registered sync/display
  // flags describe the same pixel that hpos/vpos show after the edge.
  always_comb begin
    h_sync_zone = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    v_sync_zone = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    visible     = (h_next < H_VIS) && (v_next < V_VIS);
  end

  // Reset parks the position on the last raster pixel so the first pixel
  // step after release wraps cleanly to (0, 0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt   <= 4'd0;
      pix_en_q  <= 1'b0;
      hpos_q    <= H_LAST;
      vpos_q    <= V_LAST;
      hsync_q   <= SYNC_OFF;
      vsync_q   <= SYNC_OFF;
      display_q <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      div_cnt   <= div_next;
      pix_en_q  <= step;
      hpos_q    <= h_next;
      vpos_q    <= v_next;
      hsync_q   <= h_sync_zone ? SYNC_ON : SYNC_OFF;
      vsync_q   <= v_sync_zone ? SYNC_ON : SYNC_OFF;
      display_q <= visible;
      line_q    <= step && (h_next == '0);
      frame_q   <= step && (h_next == '0) && (v_next == '0);
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = display_q;
  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule
